// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bus: byte request handshake, raw pin levels in,
// open-drain pull-down enables out, and frame status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data bits,
// odd parity and stop on device clocks, then check the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned RTS_CYCLES     = 500,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned BIT_TIMEOUT    = 200000
) (
    input logic          clk,
    input logic          rst,
    ps2_host_tx_if.slave bus
);
    localparam int unsigned MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned MAX_B = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST   = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAITIDLE, DONE, ERR
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [CW-1:0] cnt;
    logic          clk_oe_r, data_oe_r, done_r, err_r;
    logic          fall;
    logic          timeout;

    // Idle bus level is high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= bus.ps2_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= bus.ps2_data_i;
            data_s2  <= data_s1;
        end
    end

    assign fall    = clk_prev & ~clk_s2;
    assign timeout = (cnt == ((bitcnt == 4'd0) ? START_LAST : BIT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            cnt       <= '0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shreg     <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        bitcnt    <= '0;
                        cnt       <= '0;
                        clk_oe_r  <= 1'b1;
                        data_oe_r <= 1'b0;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt       <= '0;
                        data_oe_r <= 1'b1;
                        state     <= RTS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt      <= '0;
                        clk_oe_r <= 1'b0;
                        state    <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A fall wins over a coincident timeout: the device did clock in time.
                SEND: begin
                    if (fall) begin
                        data_oe_r <= ~shreg[0];
                        shreg     <= {1'b0, shreg[9:1]};
                        bitcnt    <= bitcnt + 4'd1;
                        cnt       <= '0;
                        if (bitcnt == 4'd9) state <= ACK;
                    end else if (timeout) begin
                        data_oe_r <= 1'b0;
                        err_r     <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (fall) begin
                        cnt <= '0;
                        if (data_s2) begin
                            data_oe_r <= 1'b0;
                            err_r     <= 1'b1;
                            state     <= ERR;
                        end else begin
                            state <= WAITIDLE;
                        end
                    end else if (timeout) begin
                        data_oe_r <= 1'b0;
                        err_r     <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAITIDLE: begin
                    if (clk_s2 && data_s2) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        data_oe_r <= 1'b0;
                        err_r     <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    state     <= IDLE;
                end
                ERR: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready    = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.ps2_clk_oe  = clk_oe_r;
    assign bus.ps2_data_oe = data_oe_r;
    assign bus.tx_done     = done_r;
    assign bus.tx_err      = err_r;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model plus a cycle-level
// behavioural reference of the host frame timeline checked on every clock.
module tb_ps2_host_tx;
    localparam int I = 40;
    localparam int R = 10;
    localparam int S = 300;
    localparam int B = 100;

    logic clk;
    logic rst;
    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(I),
        .RTS_CYCLES    (R),
        .START_TIMEOUT (S),
        .BIT_TIMEOUT   (B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int errors  = 0;

    // device model state
    int         dev_mode  = 0;   // 0 silent, 1 clocks and ACKs, 2 clocks without ACK
    int         dev_half  = 20;
    int         dev_delay = 10;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [9:0] dev_bits = '0;
    int         dev_nbits = 0;
    bit         dev_active = 1'b0;

    assign bus.ps2_clk_i  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_i = ~(bus.ps2_data_oe | dev_data_low);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Device: after request-to-send, 11 clock pulses; reads a bit after each
    // rising edge, and on pulse 11 pulls data low as ACK (mode 1).
    initial begin
        forever begin
            @(posedge clk); #2;
            if (dev_mode != 0 && bus.ps2_clk_i && !bus.ps2_data_i) begin
                dev_active = 1'b1;
                dev_nbits  = 0;
                repeat (dev_delay) @(posedge clk);
                #2;
                for (int k = 1; k <= 11; k++) begin
                    if (k == 11 && dev_mode == 1) begin
                        dev_data_low = 1'b1;
                        repeat (3) @(posedge clk);
                        #2;
                    end
                    dev_clk_low = 1'b1;
                    repeat (dev_half) @(posedge clk);
                    #2;
                    dev_clk_low = 1'b0;
                    repeat (dev_half) @(posedge clk);
                    #2;
                    if (k <= 10) begin
                        dev_bits[k-1] = bus.ps2_data_i;
                        dev_nbits     = k;
                    end else begin
                        dev_data_low = 1'b0;
                    end
                end
                dev_active = 1'b0;
            end
        end
    end

    // pin levels as the DUT's first synchroniser flop will capture them
    logic pc_neg, pd_neg;
    initial begin
        forever begin
            @(negedge clk);
            pc_neg = bus.ps2_clk_i;
            pd_neg = bus.ps2_data_i;
        end
    end

    // accept / done edge log
    int ecyc = 0;
    int last_done_e = -100;
    int acc_q[$];
    int gap_q[$];
    always @(posedge clk) begin
        ecyc++;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            acc_q.push_back(ecyc);
            gap_q.push_back(ecyc - last_done_e);
        end
        if (bus.tx_done) last_done_e = ecyc;
    end

    // reference model + per-cycle compare
    int   cyc = 0;
    bit   m_busy = 1'b0;
    int   m_term = 0;            // 1 done, 2 error, reported on this cycle
    int   m_acc, m_last, m_nf;
    bit   m_wait;
    logic [9:0] m_frame;
    int   done_cnt = 0, err_cnt = 0;
    int   inh_run = 0, inh_last = 0, rts_run = 0, rts_last = 0;
    int   send_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0;

    initial begin
        logic [3:0] hc, hd;
        logic       fall_m, dexp;
        logic [5:0] got, exp;
        int         age;
        hc = '1;
        hd = '1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            hc = {hc[2:0], pc_neg};
            hd = {hd[2:0], pd_neg};
            fall_m = hc[3] & ~hc[2];
            if (rst) begin
                m_busy = 1'b0;
                m_term = 0;
            end else begin
                if (!m_busy) begin
                    if (bus.tx_valid) begin
                        m_busy  = 1'b1;
                        m_acc   = cyc;
                        m_frame = {1'b1, ~^bus.tx_data, bus.tx_data};
                        m_nf    = 0;
                        m_wait  = 1'b0;
                    end
                end else if (m_term != 0) begin
                    m_busy = 1'b0;
                    m_term = 0;
                end else if (cyc - m_acc == I + R) begin
                    m_last = cyc;
                end else if (cyc - m_acc > I + R) begin
                    if (m_wait) begin
                        if (hc[2] && hd[2]) m_term = 1;
                        else if (fall_m) m_last = cyc;
                        else if (cyc - m_last == B) m_term = 2;
                    end else if (fall_m) begin
                        m_nf++;
                        m_last = cyc;
                        if (m_nf == 11) begin
                            if (hd[2]) m_term = 2;
                            else m_wait = 1'b1;
                        end
                    end else if (cyc - m_last == ((m_nf == 0) ? S : B)) begin
                        m_term = 2;
                    end
                end

                age  = cyc - m_acc;
                dexp = (m_nf == 0) ? 1'b1 : ((m_nf <= 10) ? ~m_frame[m_nf-1] : 1'b0);
                if (!m_busy)          exp = 6'b100000;
                else if (m_term == 1) exp = 6'b010010;
                else if (m_term == 2) exp = 6'b010001;
                else if (age < I)     exp = 6'b011000;
                else if (age < I + R) exp = 6'b011100;
                else                  exp = {3'b010, dexp, 2'b00};

                got = {bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_done, bus.tx_err};
                check("cycle {ready,busy,clk_oe,data_oe,done,err}", {26'd0, got}, {26'd0, exp});

                if (got[1]) done_cnt++;
                if (got[0]) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (prev_clk_oe && !got[3] && got[4]) send_cyc = cyc;
                if (got[3] && !got[2]) inh_run++;
                else begin
                    if (inh_run != 0) inh_last = inh_run;
                    inh_run = 0;
                end
                if (got[3] && got[2]) rts_run++;
                else begin
                    if (rts_run != 0) rts_last = rts_run;
                    rts_run = 0;
                end
            end
            prev_clk_oe = bus.ps2_clk_oe;
        end
    end

    task automatic wait_end(output int res);
        res = 0;
        for (int i = 0; i < 4000 && res == 0; i++) begin
            @(negedge clk);
            if (bus.tx_done) res = 1;
            else if (bus.tx_err) res = 2;
        end
        if (res == 0) begin
            vectors++;
            errors++;
            $display("FAIL end_wait: no tx_done/tx_err within 4000 cycles");
        end
    endtask

    task automatic send(input logic [7:0] d, output int res);
        int n;
        n = 0;
        while (!bus.tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready before send", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_end(res);
    endtask

    task automatic wait_dev_idle();
        for (int i = 0; i < 3000 && dev_active; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int res, d0, e0, a0, n;
        logic [7:0] rb;
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {26'd0, bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_done, bus.tx_err},
              32'b100000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED with ACK
        dev_mode = 1;
        d0 = done_cnt;
        send(8'hED, res);
        check("t1 result", res, 1);
        check("t1 device frame", {22'd0, dev_bits}, 32'h3ED);
        check("t1 inhibit length", inh_last, I);
        check("t1 rts length", rts_last, R);
        wait_dev_idle();
        check("t1 done pulses", done_cnt - d0, 1);

        // parity of 0x01, 0x00, 0xFF
        send(8'h01, res);
        check("t2 01 result", res, 1);
        check("t2 01 frame", {22'd0, dev_bits}, 32'h201);
        wait_dev_idle();
        send(8'h00, res);
        check("t2 00 result", res, 1);
        check("t2 00 parity", {31'd0, dev_bits[8]}, 32'd1);
        wait_dev_idle();
        send(8'hFF, res);
        check("t2 FF result", res, 1);
        check("t2 FF frame", {22'd0, dev_bits}, 32'h3FF);
        wait_dev_idle();

        // silent device: start timeout
        dev_mode = 0;
        send(8'h5A, res);
        check("t3 result", res, 2);
        check("t3 err latency", err_cyc - send_cyc, S);
        check("t3 oe released", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        repeat (5) @(negedge clk);

        // clocks but no ACK
        dev_mode = 2;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA7, res);
        check("t4 result", res, 2);
        wait_dev_idle();
        check("t4 no done", done_cnt - d0, 0);
        check("t4 one err", err_cnt - e0, 1);

        // asynchronous reset mid-frame
        dev_mode = 1;
        wait (bus.tx_ready);
        @(negedge clk);
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n = 0;
        while (!(dev_active && dev_nbits == 4) && n < 3000) begin
            @(posedge clk); #3;
            n++;
        end
        check("t5 reached bit 4", {31'd0, dev_active}, 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t5 async oe clear", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5 ready after reset", {31'd0, bus.tx_ready}, 32'd1);
        wait_dev_idle();
        send(8'hFF, res);
        check("t5 FF result", res, 1);
        check("t5 FF frame", {22'd0, dev_bits}, 32'h3FF);
        wait_dev_idle();

        // tx_valid held high: back-to-back frames
        d0 = done_cnt;
        a0 = acc_q.size();
        bus.tx_data  = 8'hF4;
        bus.tx_valid = 1'b1;
        n = 0;
        while (acc_q.size() < a0 + 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        bus.tx_valid = 1'b0;
        check("t6 accepts", acc_q.size() - a0, 2);
        if (acc_q.size() >= a0 + 2) check("t6 accept after done", gap_q[a0+1], 1);
        wait_end(res);
        check("t6 second result", res, 1);
        check("t6 frame", {22'd0, dev_bits}, {22'd0, 1'b1, ~^8'hF4, 8'hF4});
        wait_dev_idle();
        check("t6 done pulses", done_cnt - d0, 2);

        // randomized bytes, device timing
        for (int t = 0; t < 6; t++) begin
            rb        = 8'($urandom);
            dev_half  = $urandom_range(12, 25);
            dev_delay = $urandom_range(5, 40);
            send(rb, res);
            check("rand result", res, 1);
            check("rand frame", {22'd0, dev_bits}, {22'd0, 1'b1, ~^rb, rb});
            wait_dev_idle();
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
